opr_sequencer: RTL and testbench

Multi-cycle executor for PDP-8 operate instructions (opcode 7). It accepts an instruction plus the architectural AC, L, PC and SR values, then applies the micro-operations in PDP-8 event order, one sequence step per clock. It returns the updated AC, L and PC, plus a halt flag, with a start/done handshake. It sits in the CPU execute stage and consumes the same operate-group encoding that the combinational micro decoder evaluates.

---
 rtl/opr_sequencer_pkg.sv | 57 +++++
 rtl/opr_sequencer_if.sv | 28 ++
 rtl/opr_sequencer_skip_eval.sv | 19 +
 rtl/opr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_opr_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/opr_sequencer_pkg.sv
// Shared types and IR field positions for the PDP-8 operate-instruction sequencer.
// Also holds the 13-bit {L,AC} rotate helpers.
package opr_sequencer_pkg;

   typedef logic [11:0] word;

   typedef enum logic [3:0] {
      IDLE,
      G1_CLR,
      G1_CMP,
      G1_INC,
      G1_ROT1,
      G1_ROT2,
      G2_TEST,
      G2_CLA,
      G2_OSR,
      OP_NOP,
      DONE
   } opr_state_t;

   localparam logic [2:0] OPC_OPR = 3'o7;

   // Group 1 bit positions
   localparam int BIT_GRP = 8;
   localparam int BIT_CLA = 7;
   localparam int BIT_CLL = 6;
   localparam int BIT_CMA = 5;
   localparam int BIT_CML = 4;
   localparam int BIT_RAR = 3;
   localparam int BIT_RAL = 2;
   localparam int BIT_BSW = 1;
   localparam int BIT_IAC = 0;

   // Group 2 bit positions
   localparam int BIT_SMA   = 6;
   localparam int BIT_SZA   = 5;
   localparam int BIT_SNL   = 4;
   localparam int BIT_SENSE = 3;
   localparam int BIT_OSR   = 2;
   localparam int BIT_HLT   = 1;

   // {RAR, RAL, BSW} select codes
   localparam logic [2:0] ROT_RAR = 3'b100;
   localparam logic [2:0] ROT_RAL = 3'b010;
   localparam logic [2:0] ROT_BSW = 3'b001;
   localparam logic [2:0] ROT_RTR = 3'b101;
   localparam logic [2:0] ROT_RTL = 3'b011;

   function automatic logic [12:0] rot_right13(input logic l, input word ac);
      return {ac[0], l, ac[11:1]};
   endfunction

   function automatic logic [12:0] rot_left13(input logic l, input word ac);
      return {ac, l};
   endfunction

endpackage

// File: rtl/opr_sequencer_if.sv
// Request/response bundle between the execute stage and the operate sequencer.
interface opr_sequencer_if;
   import opr_sequencer_pkg::*;

   logic        start;
   logic [11:0] i_reg;
   word         ac_in;
   logic        l_in;
   word         pc_in;
   word         sr;
   logic        clear_halt;
   logic        busy;
   logic        done;
   word         ac_out;
   logic        l_out;
   word         pc_out;
   logic        halt;

   modport master (
      output start, i_reg, ac_in, l_in, pc_in, sr, clear_halt,
      input  busy, done, ac_out, l_out, pc_out, halt
   );

   modport slave (
      input  start, i_reg, ac_in, l_in, pc_in, sr, clear_halt,
      output busy, done, ac_out, l_out, pc_out, halt
   );
endinterface

// File: rtl/opr_sequencer_skip_eval.sv
// Group 2 skip condition: OR form of SMA/SZA/SNL, or its complement when the sense bit is set.
module opr_skip_eval
   import opr_sequencer_pkg::*;
(
   input  logic [6:3] ir_i,
   input  word        ac_i,
   input  logic       l_i,
   output logic       skip_o
);

   logic or_skip;

   // The AND form is exactly the negation of the OR form, so SKP (no tests) yields 1.
   assign or_skip = (ir_i[BIT_SMA] & ac_i[11])
                  | (ir_i[BIT_SZA] & (ac_i == '0))
                  | (ir_i[BIT_SNL] & l_i);
   assign skip_o  = ir_i[BIT_SENSE] ? ~or_skip : or_skip;

endmodule

// File: rtl/opr_sequencer.sv
// Multi-cycle PDP-8 operate executor: one micro-op step per clock in PDP-8 event order,
// with registered results and a one-cycle done pulse.
module opr_sequencer
   import opr_sequencer_pkg::*;
(
   input logic           clk,
   input logic           reset_n,
   opr_sequencer_if.slave bus
);

   opr_state_t  state_q, state_d;
   logic [7:0]  ir_q, ir_d;
   word         ac_q, ac_d;
   logic        l_q, l_d;
   word         pc_q, pc_d;
   logic        skip_q, skip_d;
   logic        halt_q, halt_d;
   word         ac_out_q, ac_out_d;
   logic        l_out_q, l_out_d;
   word         pc_out_q, pc_out_d;

   logic        skip;
   logic [12:0] inc;
   logic [2:0]  rot;
   logic        is_nop;

   opr_skip_eval u_skip (
      .ir_i   (ir_q[6:3]),
      .ac_i   (ac_q),
      .l_i    (l_q),
      .skip_o (skip)
   );

   assign inc    = {1'b0, ac_q} + 13'd1;
   assign rot    = {ir_q[BIT_RAR], ir_q[BIT_RAL], ir_q[BIT_BSW]};
   assign is_nop = (bus.i_reg[11:9] != OPC_OPR) || (bus.i_reg[BIT_GRP] && bus.i_reg[0]);

   // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      ac_d     = ac_q;
      l_d      = l_q;
      pc_d     = pc_q;
      skip_d   = skip_q;
      halt_d   = halt_q;
      ac_out_d = ac_out_q;
      l_out_d  = l_out_q;
      pc_out_d = pc_out_q;

      if (bus.clear_halt) halt_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start && !halt_q) begin
               ir_d = bus.i_reg[7:0];
               ac_d = bus.ac_in;
               l_d  = bus.l_in;
               pc_d = bus.pc_in;
               if (is_nop)                   state_d = OP_NOP;
               else if (!bus.i_reg[BIT_GRP]) state_d = G1_CLR;
               else                          state_d = G2_TEST;
            end
         end
         G1_CLR: begin
            if (ir_q[BIT_CLA]) ac_d = '0;
            if (ir_q[BIT_CLL]) l_d  = 1'b0;
            state_d = G1_CMP;
         end
         G1_CMP: begin
            if (ir_q[BIT_CMA]) ac_d = ~ac_q;
            if (ir_q[BIT_CML]) l_d  = ~l_q;
            state_d = G1_INC;
         end
         G1_INC: begin
            if (ir_q[BIT_IAC]) begin
               ac_d = inc[11:0];
               if (inc[12]) l_d = ~l_q;
            end
            state_d = G1_ROT1;
         end
         G1_ROT1: begin
            case (rot)
               ROT_RAR, ROT_RTR: {l_d, ac_d} = rot_right13(l_q, ac_q);
               ROT_RAL, ROT_RTL: {l_d, ac_d} = rot_left13(l_q, ac_q);
               ROT_BSW:          ac_d = {ac_q[5:0], ac_q[11:6]};
               default: ;
            endcase
            state_d = G1_ROT2;
         end
         G1_ROT2: begin
            case (rot)
               ROT_RTR: {l_d, ac_d} = rot_right13(l_q, ac_q);
               ROT_RTL: {l_d, ac_d} = rot_left13(l_q, ac_q);
               default: ;
            endcase
            state_d = DONE;
         end
         G2_TEST: begin
            skip_d  = skip;
            state_d = G2_CLA;
         end
         G2_CLA: begin
            if (ir_q[BIT_CLA]) ac_d = '0;
            state_d = G2_OSR;
         end
         G2_OSR: begin
            if (ir_q[BIT_OSR]) ac_d = ac_q | bus.sr;
            if (ir_q[BIT_HLT]) halt_d = 1'b1;
            pc_d    = pc_q + {11'd0, skip_q};
            state_d = DONE;
         end
         OP_NOP:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Results are published on the edge that enters DONE and held until the next one.
      if (state_d == DONE) begin
         ac_out_d = ac_d;
         l_out_d  = l_d;
         pc_out_d = pc_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         ir_q     <= '0;
         ac_q     <= '0;
         l_q      <= 1'b0;
         pc_q     <= '0;
         skip_q   <= 1'b0;
         halt_q   <= 1'b0;
         ac_out_q <= '0;
         l_out_q  <= 1'b0;
         pc_out_q <= '0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         ac_q     <= ac_d;
         l_q      <= l_d;
         pc_q     <= pc_d;
         skip_q   <= skip_d;
         halt_q   <= halt_d;
         ac_out_q <= ac_out_d;
         l_out_q  <= l_out_d;
         pc_out_q <= pc_out_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.ac_out = ac_out_q;
   assign bus.l_out  = l_out_q;
   assign bus.pc_out = pc_out_q;
   assign bus.halt   = halt_q;

endmodule

// File: tb/tb_opr_sequencer.sv
// Directed-vector bench for opr_sequencer with hand-computed octal expectations.
module tb_opr_sequencer;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   opr_sequencer_if bus ();

   opr_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [11:0] ir, input logic [11:0] ac,
                         input logic l, input logic [11:0] pc, input logic [11:0] sr,
                         input int exp_lat, input logic [11:0] exp_ac, input logic exp_l,
                         input logic [11:0] exp_pc);
      int   got_lat;
      logic busy_ok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.i_reg = ir;
      bus.ac_in = ac;
      bus.l_in  = l;
      bus.pc_in = pc;
      bus.sr    = sr;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      got_lat = -1;
      busy_ok = 1'b1;
      for (int c = 0; c <= 12; c++) begin
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.done) begin
            got_lat = c;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_lat"},  got_lat, exp_lat);
      check({tag, "_busy"}, busy_ok, 1'b1);
      check({tag, "_ac"},   bus.ac_out, exp_ac);
      check({tag, "_l"},    bus.l_out, exp_l);
      check({tag, "_pc"},   bus.pc_out, exp_pc);
      @(negedge clk);
      check({tag, "_idle"}, {bus.busy, bus.done}, 2'b00);
   endtask

   initial begin
      int   seen_busy;
      int   seen_done;

      checks          = 0;
      failures        = 0;
      reset_n         = 1'b0;
      bus.start       = 1'b0;
      bus.i_reg       = '0;
      bus.ac_in       = '0;
      bus.l_in        = 1'b0;
      bus.pc_in       = '0;
      bus.sr          = '0;
      bus.clear_halt  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out", {bus.ac_out, bus.l_out, bus.pc_out}, 25'd0);
      check("rst_ctl", {bus.busy, bus.done, bus.halt}, 3'b000);
      reset_n = 1'b1;

      // Group 1
      run_op("cla",  12'o7200, 12'o1234, 1'b1, 12'o0101, 12'o0, 5, 12'o0000, 1'b1, 12'o0101);
      run_op("iac",  12'o7001, 12'o7777, 1'b0, 12'o0102, 12'o0, 5, 12'o0000, 1'b1, 12'o0102);
      run_op("rtl",  12'o7006, 12'o4001, 1'b0, 12'o0103, 12'o0, 5, 12'o0005, 1'b0, 12'o0103);
      run_op("bsw",  12'o7002, 12'o1234, 1'b1, 12'o0104, 12'o0, 5, 12'o3412, 1'b1, 12'o0104);
      run_op("rar",  12'o7010, 12'o0001, 1'b0, 12'o0105, 12'o0, 5, 12'o0000, 1'b1, 12'o0105);
      run_op("rtr",  12'o7012, 12'o0003, 1'b0, 12'o0106, 12'o0, 5, 12'o4000, 1'b1, 12'o0106);
      run_op("cmcl", 12'o7060, 12'o1234, 1'b0, 12'o0107, 12'o0, 5, 12'o6543, 1'b1, 12'o0107);

      // Group 2
      run_op("sma1", 12'o7500, 12'o4000, 1'b0, 12'o0201, 12'o0, 3, 12'o4000, 1'b0, 12'o0202);
      run_op("sma0", 12'o7500, 12'o0001, 1'b0, 12'o0201, 12'o0, 3, 12'o0001, 1'b0, 12'o0201);
      run_op("skp",  12'o7410, 12'o0000, 1'b1, 12'o7777, 12'o0, 3, 12'o0000, 1'b1, 12'o0000);
      run_op("osr",  12'o7604, 12'o1111, 1'b0, 12'o0400, 12'o2525, 3, 12'o2525, 1'b0, 12'o0400);
      run_op("sna0", 12'o7450, 12'o0000, 1'b0, 12'o0500, 12'o0, 3, 12'o0000, 1'b0, 12'o0500);
      run_op("sna1", 12'o7450, 12'o0005, 1'b0, 12'o0500, 12'o0, 3, 12'o0005, 1'b0, 12'o0501);
      run_op("szl0", 12'o7430, 12'o0007, 1'b1, 12'o0510, 12'o0, 3, 12'o0007, 1'b1, 12'o0510);
      run_op("szl1", 12'o7430, 12'o0007, 1'b0, 12'o0510, 12'o0, 3, 12'o0007, 1'b0, 12'o0511);

      // Non-operate and group 3
      run_op("tad",  12'o1234, 12'o0777, 1'b1, 12'o0600, 12'o0, 1, 12'o0777, 1'b1, 12'o0600);
      run_op("grp3", 12'o7401, 12'o0321, 1'b0, 12'o0601, 12'o0, 1, 12'o0321, 1'b0, 12'o0601);

      // Halt and lockout
      run_op("hlt",  12'o7402, 12'o0777, 1'b0, 12'o0700, 12'o0, 3, 12'o0777, 1'b0, 12'o0700);
      check("hlt_set", bus.halt, 1'b1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.i_reg = 12'o7200;
      bus.ac_in = 12'o1234;
      seen_busy = 0;
      seen_done = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.busy) seen_busy++;
         if (bus.done) seen_done++;
      end
      bus.start = 1'b0;
      check("hlt_nobusy", seen_busy, 0);
      check("hlt_nodone", seen_done, 0);
      check("hlt_hold",   bus.ac_out, 12'o0777);
      bus.clear_halt = 1'b1;
      @(negedge clk);
      bus.clear_halt = 1'b0;
      check("hlt_clear", bus.halt, 1'b0);
      run_op("post", 12'o7001, 12'o1233, 1'b0, 12'o0300, 12'o0, 5, 12'o1234, 1'b0, 12'o0300);

      // Reset while in G1_INC
      @(negedge clk);
      bus.start = 1'b1;
      bus.i_reg = 12'o7001;
      bus.ac_in = 12'o7777;
      bus.l_in  = 1'b0;
      bus.pc_in = 12'o0123;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abrt_out", {bus.ac_out, bus.l_out, bus.pc_out}, 25'd0);
      check("abrt_ctl", {bus.busy, bus.done, bus.halt}, 3'b000);
      seen_done = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (bus.done) seen_done++;
      end
      check("abrt_nodone", seen_done, 0);
      run_op("rerun", 12'o7001, 12'o7777, 1'b0, 12'o0123, 12'o0, 5, 12'o0000, 1'b1, 12'o0123);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
